pll_lock_sequencer: RTL

- Closes the loop around the pixel-clock PLL.
- Consumes the PLL `locked` output and drives the PLL `rst` input.
- Holds the downstream pixel-domain logic (VGA timing, framebuffer readout) in reset until lock has been stable for a programmable time.
- Runs entirely on the 50 MHz reference clock, so it keeps operating when the PLL output is dead. It retries the PLL on lock timeout or loss of lock, and counts those events.

---
 rtl/pll_lock_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// Pixel-clock PLL lock sequencer: pulses the PLL reset, waits for lock to stay stable, then
// releases downstream reset. It retries on lock timeout or loss of lock and counts those events.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int unsigned MaxAB   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                    : LOCK_TIMEOUT;
  localparam int unsigned MaxLoad = (MaxAB > STABLE_CYCLES) ? MaxAB : STABLE_CYCLES;
  localparam int unsigned CntW    = (MaxLoad > 1) ? $clog2(MaxLoad) : 1;

  localparam logic [CntW-1:0] PllRstLoad  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLoad  = CntW'(STABLE_CYCLES - 1);

  localparam logic [1:0] StPllReset = 2'd0;
  localparam logic [1:0] StWaitLock = 2'd1;
  localparam logic [1:0] StStable   = 2'd2;
  localparam logic [1:0] StRun      = 2'd3;

  logic             sync1_q, lk_s_q;
  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d, rst_cnt;
  logic             boot_q, boot_d;
  logic             event_inc, lost_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic             pll_rst_q, sys_rst_q, ready_q, lock_lost_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lk_s_q  <= 1'b0;
    end else begin
      sync1_q <= locked;
      lk_s_q  <= sync1_q;
    end
  end

  // The counter resets to zero, so the first PLL reset pulse after power-up takes its
  // length from the load constant instead of the register.
  assign rst_cnt = boot_q ? PllRstLoad : cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    boot_d    = boot_q;
    event_inc = 1'b0;
    lost_d    = 1'b0;
    case (state_q)
      StPllReset: begin
        boot_d = 1'b0;
        if (rst_cnt == '0) begin
          state_d = StWaitLock;
          cnt_d   = TimeoutLoad;
        end else begin
          cnt_d = rst_cnt - CntW'(1);
        end
      end
      StWaitLock: begin
        // Lock wins over a coincident timeout.
        if (lk_s_q) begin
          state_d = StStable;
          cnt_d   = StableLoad;
        end else if (cnt_q == '0) begin
          state_d   = StPllReset;
          cnt_d     = PllRstLoad;
          event_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStable: begin
        if (!lk_s_q) begin
          state_d = StWaitLock;
          cnt_d   = TimeoutLoad;
        end else if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRun: begin
        if (!lk_s_q) begin
          state_d   = StPllReset;
          cnt_d     = PllRstLoad;
          event_inc = 1'b1;
          lost_d    = 1'b1;
        end
      end
      default: begin
        state_d = StPllReset;
        cnt_d   = PllRstLoad;
      end
    endcase
  end

  assign event_cnt_d = (event_inc && (event_cnt_q != '1)) ? event_cnt_q + CNT_W'(1)
                                                          : event_cnt_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= StPllReset;
      cnt_q       <= '0;
      boot_q      <= 1'b1;
      event_cnt_q <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boot_q      <= boot_d;
      event_cnt_q <= event_cnt_d;
      // Outputs decode the next state so they change on the edge that enters it.
      pll_rst_q   <= (state_d == StPllReset);
      sys_rst_q   <= (state_d != StRun);
      ready_q     <= (state_d == StRun);
      lock_lost_q <= lost_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign event_cnt = event_cnt_q;

endmodule
